// File: rtl/mem_fill_arbiter.sv
// Memory fill arbiter: serialises I-cache/D-cache block fills and D-cache write-through stores.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention instead of fixed D-cache priority.
module mem_fill_arbiter #(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned MEM_LATENCY     = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               icache_req,
  input  logic [ADDR_W-1:0]                  icache_addr,
  input  logic                               dcache_req,
  input  logic [ADDR_W-1:0]                  dcache_addr,
  input  logic                               dcache_wr,
  input  logic [DATA_W-1:0]                  dcache_wdata,
  output logic                               mem_en,
  output logic                               mem_wr,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_wdata,
  input  logic [DATA_W-1:0]                  mem_rdata,
  input  logic                               mem_rvalid,
  output logic                               fill_valid,
  output logic [DATA_W-1:0]                  fill_data,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_idx,
  output logic                               fill_sel,
  output logic                               icache_done,
  output logic                               dcache_done,
  output logic                               busy
);

  localparam int unsigned IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CNT_W = IDX_W + 1;
  // Byte offset bits within a block of 2-byte words
  localparam int unsigned OFS_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((64'd1 << OFS_W) - 64'd1);

  if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0 || MEM_LATENCY < 1)
  begin : g_bad_params
    $error("mem_fill_arbiter: illegal parameterisation");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [CNT_W-1:0]    icnt_q;
  logic [IDX_W-1:0]    rcnt_q;
  logic                grant_d;
  logic                take;
  logic [ADDR_W-1:0]   fill_base;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q;

  assign grant_d = dcache_req && (!icache_req || !last_d_q);

  // Remember who was granted last so contention alternates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else if (take) begin
      last_d_q <= grant_d;
    end
  end
`else
  assign grant_d = dcache_req;
`endif

  assign take      = (state_q == ST_IDLE) && (icache_req || dcache_req);
  assign fill_base = addr_q & ~OFS_MASK;

  // State, latched request and word counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      icnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        owner_q <= grant_d;
        addr_q  <= grant_d ? dcache_addr : icache_addr;
        data_q  <= grant_d ? dcache_wdata : '0;
        icnt_q  <= '0;
        rcnt_q  <= '0;
      end else begin
        if (mem_en && !mem_wr) icnt_q <= icnt_q + CNT_W'(1);
        if (fill_valid)        rcnt_q <= rcnt_q + IDX_W'(1);
      end
    end
  end

  // Next state and memory/fill/done outputs
  always_comb begin
    state_d     = state_q;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_valid  = 1'b0;
    fill_data   = '0;
    fill_idx    = '0;
    fill_sel    = 1'b0;
    icache_done = 1'b0;
    dcache_done = 1'b0;
    busy        = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (take) state_d = (grant_d && dcache_wr) ? ST_WRITE : ST_FILL;
      end
      ST_FILL: begin
        if (icnt_q < CNT_W'(WORDS_PER_BLOCK)) begin
          mem_en   = 1'b1;
          mem_addr = fill_base + ADDR_W'({icnt_q, 1'b0});
        end
        // Returns pass straight through; leaving FILL on the last one drops any extras
        if (mem_rvalid) begin
          fill_valid = 1'b1;
          fill_data  = mem_rdata;
          fill_idx   = rcnt_q;
          fill_sel   = owner_q;
          if (rcnt_q == IDX_W'(WORDS_PER_BLOCK - 1)) state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = data_q;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        icache_done = !owner_q;
        dcache_done = owner_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter: vector table for arbitration/write, sequences for fills and reset.
`timescale 1ns/1ps
module tb_mem_fill_arbiter;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 16;
  localparam int unsigned WPB = 8;
  localparam int unsigned LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          icache_req = 1'b0;
  logic [AW-1:0] icache_addr = '0;
  logic          dcache_req = 1'b0;
  logic [AW-1:0] dcache_addr = '0;
  logic          dcache_wr = 1'b0;
  logic [DW-1:0] dcache_wdata = '0;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic          fill_valid;
  logic [DW-1:0] fill_data;
  logic [2:0]    fill_idx;
  logic          fill_sel;
  logic          icache_done, dcache_done, busy;

  always #5 clk = ~clk;

  mem_fill_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .dcache_req(dcache_req), .dcache_addr(dcache_addr),
    .dcache_wr(dcache_wr), .dcache_wdata(dcache_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_idx(fill_idx), .fill_sel(fill_sel),
    .icache_done(icache_done), .dcache_done(dcache_done), .busy(busy)
  );

  function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
    return DW'(a ^ AW'(16'hC3A5));
  endfunction

  // Fixed-latency memory: not reset, so returns keep coming after a DUT reset
  bit          pv [LAT];
  bit [AW-1:0] pa [LAT];
  always @(posedge clk) begin
    pv[0] <= mem_en & ~mem_wr;
    pa[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign mem_rvalid = pv[LAT-1];
  assign mem_rdata  = rdata_of(pa[LAT-1]);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read-address and fill-stream scoreboard for the currently armed operation
  logic [AW-1:0] mon_base = '0;
  logic          mon_sel  = 1'b0;
  int            reads = 0;
  int            rets  = 0;

  task automatic arm(input logic [AW-1:0] base, input logic sel);
    mon_base = base;
    mon_sel  = sel;
    reads    = 0;
    rets     = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en && !mem_wr) begin
        check("rd_addr", 64'(mem_addr), 64'(AW'(mon_base + AW'(2 * reads))));
        reads++;
      end
      if (fill_valid) begin
        check("fill_idx", 64'(fill_idx), 64'(rets));
        check("fill_sel", 64'(fill_sel), 64'(mon_sel));
        check("fill_data", 64'(fill_data), 64'(rdata_of(AW'(mon_base + AW'(2 * rets)))));
        rets++;
      end
    end
  end

  task automatic wait_done(input string tag, input logic sel, input int exp_cyc,
                           input bit is_fill, input int drop_at);
    int cyc = 0;
    int idn = 0;
    int ddn = 0;
    bit seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (icache_done) idn++;
      if (dcache_done) ddn++;
      if (icache_done || dcache_done) begin
        seen = 1;
        if (sel) begin
          dcache_req = 1'b0;
          dcache_wr  = 1'b0;
        end else begin
          icache_req = 1'b0;
        end
      end else if (busy) begin
        cyc++;
        if (cyc == drop_at) begin
          if (sel) dcache_req = 1'b0;
          else     icache_req = 1'b0;
        end
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'(1));
    check({tag, "_done_owner"}, 64'({8'(idn), 8'(ddn)}), sel ? 64'(16'h0001) : 64'(16'h0100));
    check({tag, "_busy_cycles"}, 64'(cyc), 64'(exp_cyc));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'({icache_done, dcache_done, busy}), 64'(0));
    if (is_fill) begin
      check({tag, "_reads"}, 64'(reads), 64'(WPB));
      check({tag, "_returns"}, 64'(rets), 64'(WPB));
    end
  endtask

  typedef struct {
    string         name;
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic          dreq;
    logic          dwr;
    logic [AW-1:0] daddr;
    logic [DW-1:0] wd;
    logic          en;
    logic          wr;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwd;
    logic          fv;
    logic          bsy;
    logic          idone;
    logic          ddone;
  } vec_t;

  localparam int NV = 7;
  vec_t tbl [NV];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    // Contention with D write, then I fill sampled in the IDLE cycle after D's done
    tbl[0] = '{"idle_contend",   1, 16'h0200, 1, 1, 16'h1002, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0};
    tbl[1] = '{"write_cycle",    1, 16'h0200, 1, 1, 16'h1002, 16'hBEEF, 1, 1, 16'h1002, 16'hBEEF, 0, 1, 0, 0};
    tbl[2] = '{"write_done",     1, 16'h0200, 1, 1, 16'h1002, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 1};
    tbl[3] = '{"idle_after_done",1, 16'h0200, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0};
    tbl[4] = '{"fill_rd0",       1, 16'h0200, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0200, 16'h0000, 0, 1, 0, 0};
    tbl[5] = '{"fill_rd1",       1, 16'h0200, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0202, 16'h0000, 0, 1, 0, 0};
    tbl[6] = '{"fill_rd2",       1, 16'h0200, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0204, 16'h0000, 0, 1, 0, 0};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_state", 64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_data,
                              fill_idx, fill_sel, icache_done, dcache_done, busy}), 64'(0));

    arm(16'h0200, 1'b0);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      icache_req   = tbl[i].ireq;
      icache_addr  = tbl[i].iaddr;
      dcache_req   = tbl[i].dreq;
      dcache_wr    = tbl[i].dwr;
      dcache_addr  = tbl[i].daddr;
      dcache_wdata = tbl[i].wd;
      check(tbl[i].name,
            64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, busy, icache_done, dcache_done}),
            64'({tbl[i].en, tbl[i].wr, tbl[i].maddr, tbl[i].mwd, tbl[i].fv, tbl[i].bsy,
                 tbl[i].idone, tbl[i].ddone}));
    end
    wait_done("tbl_ifill", 1'b0, 9, 1'b1, -1);

    // Two back-to-back contentions
    @(negedge clk);
    arm(16'h0300, 1'b0);
    icache_req = 1'b1; icache_addr = 16'h0300;
    dcache_req = 1'b1; dcache_wr = 1'b1; dcache_addr = 16'h2004; dcache_wdata = 16'h1111;
    @(negedge clk);
    check("contend1_write", 64'({mem_en, mem_wr, mem_addr, mem_wdata}), 64'({2'b11, 16'h2004, 16'h1111}));
    @(negedge clk);
    check("contend1_done", 64'({dcache_done, icache_done}), 64'(2'b10));
    dcache_addr = 16'h2006; dcache_wdata = 16'h2222;
    @(negedge clk);
    check("contend2_idle", 64'(busy), 64'(0));
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    check("contend2_grant", 64'({mem_en, mem_wr, mem_addr}), 64'({2'b10, 16'h0300}));
    wait_done("rr_ifill", 1'b0, 11, 1'b1, -1);
    wait_done("rr_dwrite", 1'b1, 1, 1'b0, -1);
`else
    check("contend2_grant", 64'({mem_en, mem_wr, mem_addr}), 64'({2'b11, 16'h2006}));
    wait_done("fix_dwrite", 1'b1, 0, 1'b0, -1);
    wait_done("fix_ifill", 1'b0, 12, 1'b1, -1);
`endif

    // I-cache fill from an unaligned miss address
    arm(16'h0030, 1'b0);
    icache_req = 1'b1; icache_addr = 16'h0036;
    wait_done("ifill_0036", 1'b0, 12, 1'b1, -1);

    // D-cache read fill
    arm(16'h1230, 1'b1);
    dcache_req = 1'b1; dcache_wr = 1'b0; dcache_addr = 16'h123A;
    wait_done("dfill_123a", 1'b1, 12, 1'b1, -1);

    // Top-of-memory block, request dropped mid-fill
    arm(16'hFFF0, 1'b0);
    icache_req = 1'b1; icache_addr = 16'hFFF4;
    wait_done("ifill_fff4", 1'b0, 12, 1'b1, 5);

    // Reset after three returns
    arm(16'h0400, 1'b0);
    icache_req = 1'b1; icache_addr = 16'h0408;
    for (int t = 0; t < 40 && rets < 3; t++) @(negedge clk);
    check("rst_pre_returns", 64'(rets >= 3), 64'(1));
    #2 rst_n = 1'b0;
    #1 check("rst_async_outputs", 64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_data,
                                       fill_idx, fill_sel, icache_done, dcache_done, busy}), 64'(0));
    icache_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (busy || fill_valid || icache_done || dcache_done || mem_en) bad++;
    end
    check("rst_stale_ignored", 64'(bad), 64'(0));

    arm(16'h0510, 1'b0);
    icache_req = 1'b1; icache_addr = 16'h051E;
    wait_done("post_rst_fill", 1'b0, 12, 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
